// File: rtl/ad4008_pkg.sv
// ad4008_pkg: shared types for the AD4008 readout chain.
// Holds the default sample width, the sample type used by the readout driver
// and the averager state enum. Optional feature macro used by this chain:
// AD4008_MINMAX_EN (per-window min/max tracking in the averager).
package ad4008_pkg;

  localparam int AD4008_ADC_WIDTH = 16;

  typedef logic [AD4008_ADC_WIDTH-1:0] sample_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } avg_state_t;

  // Number of samples in one boxcar window for a given log2 window length.
  function automatic int windowLength(input int log2n);
    return 1 << log2n;
  endfunction

endpackage

// File: rtl/ad4008_sample_averager_if.sv
// ad4008_sample_averager_if: sample strobe input plus decimated valid/ready
// output of the averager. The master modport is the upstream/consumer side,
// the slave modport is the averager itself.
// With AD4008_MINMAX_EN defined the bus also carries min_data/max_data.
interface ad4008_sample_averager_if #(
  parameter int ADC_WIDTH = 16,
  parameter int LOG2_N    = 4
) ();

  logic [ADC_WIDTH-1:0] sample_in;
  logic                 sample_valid;
  logic                 enable;
  logic [ADC_WIDTH-1:0] avg_data;
  logic                 avg_valid;
  logic                 avg_ready;
  logic [LOG2_N:0]      sample_count;
  logic                 overrun;
  logic                 overrun_clear;
`ifdef AD4008_MINMAX_EN
  logic [ADC_WIDTH-1:0] min_data;
  logic [ADC_WIDTH-1:0] max_data;
`endif

  modport master (
    output sample_in,
    output sample_valid,
    output enable,
    output avg_ready,
    output overrun_clear,
    input  avg_data,
    input  avg_valid,
    input  sample_count,
`ifdef AD4008_MINMAX_EN
    input  min_data,
    input  max_data,
`endif
    input  overrun
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  enable,
    input  avg_ready,
    input  overrun_clear,
    output avg_data,
    output avg_valid,
    output sample_count,
`ifdef AD4008_MINMAX_EN
    output min_data,
    output max_data,
`endif
    output overrun
  );

endinterface

// File: rtl/ad4008_avg_holdreg.sv
// ad4008_avg_holdreg: one-deep output holding register for the averager.
// A completed window result is accepted when the register is empty or is
// being emptied by a handshake in the same cycle; otherwise it is dropped and
// the sticky overrun flag is raised. With AD4008_MINMAX_EN defined the
// window min/max travel alongside the average under the same rules.
module ad4008_avg_holdreg
  import ad4008_pkg::*;
#(
  parameter int ADC_WIDTH = AD4008_ADC_WIDTH
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 i_load,
  input  logic [ADC_WIDTH-1:0] i_avg,
`ifdef AD4008_MINMAX_EN
  input  logic [ADC_WIDTH-1:0] i_min,
  input  logic [ADC_WIDTH-1:0] i_max,
  output logic [ADC_WIDTH-1:0] o_min,
  output logic [ADC_WIDTH-1:0] o_max,
`endif
  input  logic                 i_ready,
  input  logic                 i_overrunClear,
  output logic                 o_valid,
  output logic [ADC_WIDTH-1:0] o_data,
  output logic                 o_overrun
);

  logic                 r_valid;
  logic [ADC_WIDTH-1:0] r_data;
  logic                 r_overrun;
`ifdef AD4008_MINMAX_EN
  logic [ADC_WIDTH-1:0] r_min;
  logic [ADC_WIDTH-1:0] r_max;
`endif

  logic w_xfer;
  logic w_accept;
  logic w_drop;

  assign w_xfer   = r_valid & i_ready;
  assign w_accept = i_load & (~r_valid | w_xfer);
  assign w_drop   = i_load & r_valid & ~i_ready;

  // Load/keep the pending result and track valid plus the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
`ifdef AD4008_MINMAX_EN
      r_min     <= '0;
      r_max     <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= i_avg;
`ifdef AD4008_MINMAX_EN
        r_min   <= i_min;
        r_max   <= i_max;
`endif
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_overrunClear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_overrun = r_overrun;
`ifdef AD4008_MINMAX_EN
  assign o_min     = r_min;
  assign o_max     = r_max;
`endif

endmodule

// File: rtl/ad4008_sample_averager.sv
// ad4008_sample_averager: boxcar-averages 2**LOG2_N consecutive AD4008
// samples and presents the decimated result through ad4008_avg_holdreg.
// The accumulator and IDLE/ACCUM state machine live here.
// Optional feature macro: AD4008_MINMAX_EN adds per-window unsigned
// min_data/max_data alongside avg_data.
module ad4008_sample_averager
  import ad4008_pkg::*;
#(
  parameter int ADC_WIDTH = AD4008_ADC_WIDTH,
  parameter int LOG2_N    = 4
) (
  input  logic                      clk,
  input  logic                      sreset,
  ad4008_sample_averager_if.slave   bus
);

  localparam int ACC_W = ADC_WIDTH + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int N     = windowLength(LOG2_N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  avg_state_t           r_state;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_count;
  logic                 r_done;
  logic [ADC_WIDTH-1:0] r_result;

  logic [ACC_W-1:0]     w_sum;
  logic [ADC_WIDTH-1:0] w_avg;
  logic                 w_last;

  // The sum is as wide as N full-scale samples, so it cannot wrap; the
  // average is the truncating right shift by LOG2_N.
  assign w_sum  = r_acc + ACC_W'(bus.sample_in);
  assign w_avg  = ADC_WIDTH'(w_sum >> LOG2_N);
  assign w_last = (r_count == LAST_CNT);

`ifdef AD4008_MINMAX_EN
  logic [ADC_WIDTH-1:0] r_minRun;
  logic [ADC_WIDTH-1:0] r_maxRun;
  logic [ADC_WIDTH-1:0] r_resMin;
  logic [ADC_WIDTH-1:0] r_resMax;
  logic [ADC_WIDTH-1:0] w_minNext;
  logic [ADC_WIDTH-1:0] w_maxNext;

  // Running min/max including the current sample; the first sample of a
  // window re-seeds both trackers.
  always_comb begin
    w_minNext = bus.sample_in;
    w_maxNext = bus.sample_in;
    if (r_count != '0) begin
      if (r_minRun < bus.sample_in) w_minNext = r_minRun;
      if (r_maxRun > bus.sample_in) w_maxNext = r_maxRun;
    end
  end
`endif

  // Window state machine: accumulate on strobes while enabled, emit a one-cycle
  // completion pulse with the result on the Nth sample, restart immediately.
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef AD4008_MINMAX_EN
      r_minRun <= '0;
      r_maxRun <= '0;
      r_resMin <= '0;
      r_resMax <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_acc   <= '0;
          r_count <= '0;
          if (bus.enable) begin
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (!bus.enable) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
          end else if (bus.sample_valid) begin
            if (w_last) begin
              r_acc    <= '0;
              r_count  <= '0;
              r_done   <= 1'b1;
              r_result <= w_avg;
`ifdef AD4008_MINMAX_EN
              r_resMin <= w_minNext;
              r_resMax <= w_maxNext;
`endif
            end else begin
              r_acc   <= w_sum;
              r_count <= r_count + CNT_W'(1);
`ifdef AD4008_MINMAX_EN
              r_minRun <= w_minNext;
              r_maxRun <= w_maxNext;
`endif
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_acc   <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign bus.sample_count = r_count;

  ad4008_avg_holdreg #(
    .ADC_WIDTH (ADC_WIDTH)
  ) u_holdreg (
    .clk            (clk),
    .sreset         (sreset),
    .i_load         (r_done),
    .i_avg          (r_result),
`ifdef AD4008_MINMAX_EN
    .i_min          (r_resMin),
    .i_max          (r_resMax),
    .o_min          (bus.min_data),
    .o_max          (bus.max_data),
`endif
    .i_ready        (bus.avg_ready),
    .i_overrunClear (bus.overrun_clear),
    .o_valid        (bus.avg_valid),
    .o_data         (bus.avg_data),
    .o_overrun      (bus.overrun)
  );

endmodule

// File: tb/tb_ad4008_sample_averager.sv
// tb_ad4008_sample_averager: self-checking bench for the averager with a
// window of 4 samples. Every cycle the outputs are compared with a reference
// model that keeps the current window as a list of samples and averages it
// arithmetically. Min/max checks are active when AD4008_MINMAX_EN is defined.
module tb_ad4008_sample_averager;

  localparam int ADC_WIDTH = 16;
  localparam int LOG2_N    = 2;
  localparam int N         = 1 << LOG2_N;

  logic clk = 1'b0;
  logic sreset;

  ad4008_sample_averager_if #(.ADC_WIDTH(ADC_WIDTH), .LOG2_N(LOG2_N)) bus ();

  ad4008_sample_averager #(
    .ADC_WIDTH (ADC_WIDTH),
    .LOG2_N    (LOG2_N)
  ) dut (
    .clk    (clk),
    .sreset (sreset),
    .bus    (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state.
  int winQ[$];
  bit mAccum;
  bit mPend;
  int mPendAvg, mPendMin, mPendMax;
  bit mValid;
  int mData, mMin, mMax;
  bit mOverrun;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic modelStep(input bit en, input bit sv, input int s, input bit rdy,
                           input bit clr, input bit rst);
    bit  xfer;
    bit  drop;
    longint sum;
    int  mn, mx;
    if (rst) begin
      mAccum = 0; winQ.delete(); mPend = 0;
      mValid = 0; mData = 0; mMin = 0; mMax = 0; mOverrun = 0;
    end else begin
      xfer = mValid && rdy;
      drop = 0;
      if (mPend) begin
        if (!mValid || xfer) begin
          mValid = 1; mData = mPendAvg; mMin = mPendMin; mMax = mPendMax;
        end else begin
          drop = 1;
        end
      end else if (xfer) begin
        mValid = 0;
      end
      if (drop) mOverrun = 1;
      else if (clr) mOverrun = 0;
      mPend = 0;
      if (mAccum) begin
        if (!en) begin
          mAccum = 0; winQ.delete();
        end else if (sv) begin
          winQ.push_back(s);
          if (winQ.size() == N) begin
            sum = 0; mn = winQ[0]; mx = winQ[0];
            foreach (winQ[i]) begin
              sum += winQ[i];
              if (winQ[i] < mn) mn = winQ[i];
              if (winQ[i] > mx) mx = winQ[i];
            end
            mPendAvg = int'(sum / N);
            mPendMin = mn;
            mPendMax = mx;
            mPend = 1;
            winQ.delete();
          end
        end
      end else if (en) begin
        mAccum = 1; winQ.delete();
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("avg_valid", {31'd0, bus.avg_valid}, {31'd0, mValid});
    checkOutput("avg_data", {16'd0, bus.avg_data}, mData);
    checkOutput("overrun", {31'd0, bus.overrun}, {31'd0, mOverrun});
    checkOutput("sample_count", {29'd0, bus.sample_count}, winQ.size());
`ifdef AD4008_MINMAX_EN
    checkOutput("min_data", {16'd0, bus.min_data}, mMin);
    checkOutput("max_data", {16'd0, bus.max_data}, mMax);
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input bit en, input bit sv, input int s, input bit rdy,
                               input bit clr, input bit rst);
    bus.enable        = en;
    bus.sample_valid  = sv;
    bus.sample_in     = 16'(s);
    bus.avg_ready     = rdy;
    bus.overrun_clear = clr;
    sreset            = rst;
    @(posedge clk);
    modelStep(en, sv, s, rdy, clr, rst);
    #1;
    compareAll();
  endtask

  task automatic strobe(input int s, input bit rdy);
    applyStimulus(1, 1, s, rdy, 0, 0);
  endtask

  task automatic idleCycle(input bit rdy);
    applyStimulus(1, 0, 0, rdy, 0, 0);
  endtask

  initial begin
    bit en, sv, rdy, clr, rst;
    int s, pick;

    // Reset and reset values.
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("rst_valid", {31'd0, bus.avg_valid}, 0);
    checkOutput("rst_data", {16'd0, bus.avg_data}, 0);
    checkOutput("rst_overrun", {31'd0, bus.overrun}, 0);
    checkOutput("rst_count", {29'd0, bus.sample_count}, 0);

    // Four strobes of 0xAAAA, result one cycle after the fourth.
    applyStimulus(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) strobe(16'hAAAA, 1);
    checkOutput("aaaa_latency", {31'd0, bus.avg_valid}, 0);
    idleCycle(1);
    checkOutput("aaaa_valid", {31'd0, bus.avg_valid}, 1);
    checkOutput("aaaa_data", {16'd0, bus.avg_data}, 32'h0000AAAA);

    // Truncating average and full-scale window.
    for (int i = 0; i < 4; i++) strobe(16'h00F0 + i, 1);
    idleCycle(1);
    checkOutput("f0_data", {16'd0, bus.avg_data}, 32'h000000F1);
    for (int i = 0; i < 4; i++) strobe(16'hFFFF, 1);
    idleCycle(1);
    checkOutput("ffff_data", {16'd0, bus.avg_data}, 32'h0000FFFF);
    idleCycle(1);

    // Back-pressure across two windows drops the second one.
    for (int i = 0; i < 4; i++) strobe(16'h0100, 0);
    idleCycle(0);
    for (int i = 0; i < 4; i++) strobe(16'h0200, 0);
    idleCycle(0);
    checkOutput("ovr_data", {16'd0, bus.avg_data}, 32'h00000100);
    checkOutput("ovr_flag", {31'd0, bus.overrun}, 1);
    idleCycle(1);
    checkOutput("ovr_accept", {31'd0, bus.avg_valid}, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    checkOutput("ovr_clear", {31'd0, bus.overrun}, 0);

    // Completion coincident with a handshake replaces the held value.
    for (int i = 0; i < 4; i++) strobe(16'h0300, 0);
    idleCycle(0);
    for (int i = 0; i < 4; i++) strobe(16'h0400, 0);
    idleCycle(1);
    checkOutput("coin_valid", {31'd0, bus.avg_valid}, 1);
    checkOutput("coin_data", {16'd0, bus.avg_data}, 32'h00000400);
    checkOutput("coin_overrun", {31'd0, bus.overrun}, 0);
    idleCycle(1);

    // Disable discards a partial window; strobes in IDLE are ignored.
    strobe(16'hFFFF, 1);
    strobe(16'hFFFF, 1);
    checkOutput("part_count", {29'd0, bus.sample_count}, 2);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("dis_count", {29'd0, bus.sample_count}, 0);
    applyStimulus(0, 1, 16'h1234, 1, 0, 0);
    checkOutput("idle_count", {29'd0, bus.sample_count}, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) strobe(16'h0010, 1);
    idleCycle(1);
    checkOutput("fresh_data", {16'd0, bus.avg_data}, 32'h00000010);

    // Reset mid-window, then with a result pending.
    for (int i = 1; i <= 3; i++) strobe(i, 1);
    checkOutput("mid_count", {29'd0, bus.sample_count}, 3);
    applyStimulus(1, 1, 16'h7777, 1, 1, 1);
    checkOutput("mid_rst_count", {29'd0, bus.sample_count}, 0);
    checkOutput("mid_rst_data", {16'd0, bus.avg_data}, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) strobe(16'h0500, 0);
    idleCycle(0);
    checkOutput("pend_valid", {31'd0, bus.avg_valid}, 1);
    applyStimulus(1, 1, 16'h7777, 0, 0, 1);
    checkOutput("pend_rst_valid", {31'd0, bus.avg_valid}, 0);
    checkOutput("pend_rst_data", {16'd0, bus.avg_data}, 0);

    // Min/max window 5,9,1,7.
    applyStimulus(1, 0, 0, 1, 0, 0);
    strobe(5, 1); strobe(9, 1); strobe(1, 1); strobe(7, 1);
    idleCycle(1);
    checkOutput("mm_avg", {16'd0, bus.avg_data}, 5);
`ifdef AD4008_MINMAX_EN
    checkOutput("mm_min", {16'd0, bus.min_data}, 1);
    checkOutput("mm_max", {16'd0, bus.max_data}, 9);
`endif

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      en   = ($urandom_range(0, 19) != 0);
      sv   = ($urandom_range(0, 1) == 1);
      pick = $urandom_range(0, 7);
      if (pick == 0) s = 0;
      else if (pick == 1) s = 16'hFFFF;
      else s = $urandom_range(0, 65535);
      rdy  = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      applyStimulus(en, sv, s, rdy, clr, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
